// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic PE.
package systolic_pkg;

    localparam int unsigned DEF_A_W   = 8;
    localparam int unsigned DEF_B_W   = 8;
    localparam int unsigned DEF_ACC_W = 24;
    // Working width for the overflow check; comfortably wider than any supported ACC_W + 1.
    localparam int unsigned SUM_W     = 64;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } pe_state_t;

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    // Adds p to acc, flags results outside the acc_w-bit signed range and optionally clamps.
    // In wrap mode the caller truncates sum to acc_w bits.
    function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] acc,
                                         input logic signed [SUM_W-1:0] p,
                                         input int unsigned             acc_w,
                                         input logic                    sat);
        sat_res_t                res;
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] maxv;
        logic signed [SUM_W-1:0] minv;
        s        = acc + p;
        maxv     = (SUM_W'(64'sd1) <<< (acc_w - 32'd1)) - SUM_W'(64'sd1);
        minv     = -maxv - SUM_W'(64'sd1);
        res.ovf  = (s > maxv) || (s < minv);
        res.sum  = s;
        if (res.ovf && sat) begin
            res.sum = (s > maxv) ? maxv : minv;
        end
        return res;
    endfunction

endpackage

// File: rtl/systolic_pe_os_mac_sat.sv
// Combinational signed multiply and saturating/wrapping accumulate for one PE.
module mac_sat
    import systolic_pkg::*;
#(
    parameter int unsigned A_W   = DEF_A_W,
    parameter int unsigned B_W   = DEF_B_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter bit          SAT   = 1'b1
) (
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] prod_c,
    output logic signed [ACC_W-1:0] sum_c,
    output logic                    ovf_c
);

    localparam int unsigned P_W = A_W + B_W;

    logic signed [P_W-1:0] prod;
    sat_res_t              res;

    always_comb begin
        prod   = P_W'(a) * P_W'(b);
        prod_c = ACC_W'(prod);
        res    = sat_add(SUM_W'(acc), SUM_W'(prod), ACC_W, SAT);
        sum_c  = ACC_W'(res.sum);
        ovf_c  = res.ovf;
    end

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary PE: operand forwarding, local accumulate, and a psum drain chain.
module systolic_pe_os
    import systolic_pkg::*;
#(
    parameter int unsigned A_W   = DEF_A_W,
    parameter int unsigned B_W   = DEF_B_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter bit          SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    drain,
    input  logic signed [A_W-1:0]   a_in,
    input  logic                    a_vld_in,
    input  logic signed [B_W-1:0]   b_in,
    input  logic                    b_vld_in,
    input  logic signed [ACC_W-1:0] psum_in,
    input  logic                    psum_vld_in,
    output logic signed [A_W-1:0]   a_out,
    output logic                    a_vld_out,
    output logic signed [B_W-1:0]   b_out,
    output logic                    b_vld_out,
    output logic signed [ACC_W-1:0] psum_out,
    output logic                    psum_vld_out,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    ovf
);

    if ((ACC_W < A_W + B_W) || (ACC_W >= SUM_W)) begin : g_width_check
        $error("systolic_pe_os: ACC_W must satisfy A_W+B_W <= ACC_W < 64");
    end

    pe_state_t               state_q;
    pe_state_t               state_d;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_d;
    logic signed [ACC_W-1:0] psum_d;
    logic                    psum_vld_d;
    logic signed [ACC_W-1:0] prod_c;
    logic signed [ACC_W-1:0] sum_c;
    logic                    sum_ovf_c;
    logic                    prod_vld_c;

    assign prod_vld_c = a_vld_in & b_vld_in;

    mac_sat #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_mac (
        .a      (a_in),
        .b      (b_in),
        .acc    (acc_out),
        .prod_c (prod_c),
        .sum_c  (sum_c),
        .ovf_c  (sum_ovf_c)
    );

    // Next-state and datapath selection; drain outranks clr, clr outranks accumulate.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_out;
        ovf_d      = ovf;
        psum_d     = psum_out;
        psum_vld_d = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (drain) begin
                    psum_d     = acc_out;
                    psum_vld_d = 1'b1;
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = S_DRAIN;
                end else if (clr) begin
                    acc_d = prod_vld_c ? prod_c : '0;
                    ovf_d = 1'b0;
                end else if (prod_vld_c) begin
                    acc_d = sum_c;
                    ovf_d = ovf | sum_ovf_c;
                end
            end
            S_DRAIN: begin
                psum_d     = psum_in;
                psum_vld_d = psum_vld_in;
                if (!drain) begin
                    state_d    = S_RUN;
                    psum_vld_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // All state, including the forwarding registers, holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            acc_out      <= '0;
            ovf          <= 1'b0;
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
            a_out        <= '0;
            a_vld_out    <= 1'b0;
            b_out        <= '0;
            b_vld_out    <= 1'b0;
        end else if (en) begin
            state_q      <= state_d;
            acc_out      <= acc_d;
            ovf          <= ovf_d;
            psum_out     <= psum_d;
            psum_vld_out <= psum_vld_d;
            a_out        <= a_in;
            a_vld_out    <= a_vld_in;
            b_out        <= b_in;
            b_vld_out    <= b_vld_in;
        end
    end

endmodule
